gain_ramp_stage: RTL and testbench
==================================

Name: gain_ramp_stage

Overview:
- Multi-channel fixed-point gain stage for the reverb datapath (dry/wet and feedback gains).
- Streams signed sample frames through a 2-stage multiply/saturate pipeline with valid/ready handshakes.
- Gain changes ramp linearly, one step per accepted frame, which prevents zipper noise.
- Generalises the existing 0.25-step integer gain to parametrised data width, gain format and channel count.

Parameters:
- DATA_W, 24: signed sample width per channel.
- CHANNELS, 2: channels per frame; all channels share one gain.
- GAIN_INT_W, 4: unsigned integer bits of gain.
- GAIN_FRAC_W, 2: fractional bits of gain; 2 gives 0.25 steps.
- RAMP_STEP, 1: gain LSBs moved per accepted frame while ramping; must be ≥1.
- RESET_GAIN, 1<<GAIN_FRAC_W: gain_current value after reset (unity).

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- gain_target  in  GAIN_INT_W+GAIN_FRAC_W  unsigned requested gain
- gain_load  in  1  one-cycle pulse; latches gain_target
- s_valid  in  1  input frame valid
- s_ready  out  1  input frame accepted when s_valid&&s_ready
- s_data  in  CHANNELS*DATA_W  signed samples; ch0 in LSBs
- m_valid  out  1  output frame valid
- m_ready  in  1  downstream ready
- m_data  out  CHANNELS*DATA_W  scaled, saturated samples
- gain_current  out  GAIN_INT_W+GAIN_FRAC_W  gain applied to the next accepted frame
- ramp_busy  out  1  high while gain_current != target
- sat_pulse  out  1  one-cycle pulse when any channel of an output frame clipped

Behaviour:
- Reset (async assert, sync release):
  - Pipeline valids, m_valid and sat_pulse are 0; m_data is 0.
  - gain_current and the internal target are RESET_GAIN; ramp_busy is 0.
- Pipeline:
  - Stage 1 registers the per-channel product: signed data × zero-extended gain, width DATA_W+GAIN_W+1.
  - Stage 2 arithmetic-shifts right by GAIN_FRAC_W, saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1], and registers m_data.
  - Latency is 2 cycles from acceptance to m_valid when unstalled; throughput is 1 frame/cycle.
- Handshake:
  - adv = !(m_valid && !m_ready); s_ready = adv.
  - When adv=0 all stages hold, and m_data and m_valid stay stable.
  - Bubbles collapse: stage 1 advances into an empty stage 2 even while downstream stalls.
- Ramp FSM: states SETTLED and RAMPING.
  - gain_load=1 latches gain_target; if it differs from gain_current the FSM enters RAMPING.
  - On each accepted frame in RAMPING, gain_current moves RAMP_STEP toward the target and clamps exactly at it without overshoot. On reaching the target the FSM returns to SETTLED.
  - An accepted frame uses gain_current sampled before that cycle's step.
  - gain_load during RAMPING replaces the target and re-evaluates direction on the next step.
  - gain_load and a frame acceptance in the same cycle: the frame uses the old gain_current, and the step is taken toward the new target.
  - No steps occur without accepted frames; the ramp pauses under stall.
  - gain_load with target == gain_current leaves the FSM SETTLED.
- Reset mid-ramp or mid-stream: in-flight frames are dropped and gain returns to RESET_GAIN.
- sat_pulse asserts with the m_valid beat of the clipped frame and only on the cycle the frame enters stage 2.

Optional Feature:
- GAIN_ROUND_EN defined: adds 2^(GAIN_FRAC_W-1) before the right shift (round half up), then saturates.
- GAIN_ROUND_EN undefined: truncating arithmetic shift (floor).
- Latency is unchanged in both cases.

Decomposition:
- Package gains_pkg holds:
  - GAIN_W function/constant (GAIN_INT_W+GAIN_FRAC_W).
  - UNITY_GAIN constant.
  - Ramp FSM state enum (SETTLED, RAMPING).
  - Saturate function.
- Sub-module gain_mac_sat: one channel's multiply, shift, round and saturate, with a stage-enable input. It is instantiated CHANNELS times in a generate loop.
- The ramp FSM and handshake live in the top.

Test Plan:
- Reset, then send 0x000100 on both channels with m_ready=1 → m_data=0x000100 on both channels 2 cycles later; sat_pulse=0.
- gain_load with target 0x6 (1.5), then 4 frames of 0x000100 with RAMP_STEP=1 → outputs use gains 1.0, 1.25, 1.5, 1.5, giving 0x100, 0x140, 0x180, 0x180; ramp_busy falls after the 2nd accept.
- Target 0x3C (15.0), input 0x7FFFFF → m_data=0x7FFFFF with sat_pulse=1. Input 0x800000 → m_data=0x800000.
- Gain 0x1 (0.25), input -3 → output -1 when truncating; output -1 with GAIN_ROUND_EN (-0.75 rounds to -1). Input 2 gives 0 truncating and 1 with GAIN_ROUND_EN (0.5 rounds up).
- Hold m_ready=0 for 5 cycles with s_valid=1 → m_data stable, s_ready=0 after the pipeline fills, gain_current frozen, no frames lost or duplicated after release.
- Assert rst_n=0 mid-ramp with 2 frames in flight → m_valid=0 immediately and gain_current=RESET_GAIN; the first post-reset frame is scaled by unity.

Source files
------------

// File: rtl/gains_pkg.sv
// Shared types and helpers for the reverb gain stage.
// Gain format helpers, ramp FSM states and a generic saturator.
package gains_pkg;

    typedef enum logic {
        SETTLED = 1'b0,
        RAMPING = 1'b1
    } ramp_state_t;

    function automatic int gain_w(input int int_w, input int frac_w);
        return int_w + frac_w;
    endfunction

    function automatic int unity_gain(input int frac_w);
        return 1 << frac_w;
    endfunction

    localparam int UNITY_GAIN = unity_gain(2);

    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/gain_mac_sat.sv
// One channel of the gain stage: multiply, shift, saturate.
// GAIN_ROUND_EN selects round-half-up instead of floor before saturation.
module gain_mac_sat
    import gains_pkg::*;
#(
    parameter int DATA_W      = 24,
    parameter int GAIN_W      = 6,
    parameter int GAIN_FRAC_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en1,
    input  logic              en2,
    input  logic [DATA_W-1:0] data,
    input  logic [GAIN_W-1:0] gain,
    output logic [DATA_W-1:0] out,
    output logic              clip
);

    localparam int PW = DATA_W + GAIN_W + 1;

    logic signed [PW-1:0] dx;
    logic signed [PW-1:0] gx;
    logic signed [PW-1:0] prod;
    logic signed [63:0]   p64;
    logic signed [63:0]   shifted;
    logic signed [63:0]   sat;

    assign dx  = {{(GAIN_W + 1){data[DATA_W-1]}}, data};
    assign gx  = {{DATA_W{1'b0}}, 1'b0, gain};
    assign p64 = {{(64 - PW){prod[PW-1]}}, prod};

`ifdef GAIN_ROUND_EN
    assign shifted = (p64 + (64'sd1 <<< (GAIN_FRAC_W - 1))) >>> GAIN_FRAC_W;
`else
    assign shifted = p64 >>> GAIN_FRAC_W;
`endif

    assign sat  = saturate(shifted, DATA_W);
    assign clip = (sat != shifted);

    // Stage 1: register the full-precision product of an accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prod <= '0;
        else if (en1)
            prod <= dx * gx;
    end

    // Stage 2: register the shifted, saturated sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out <= '0;
        else if (en2)
            out <= sat[DATA_W-1:0];
    end

endmodule

// File: rtl/gain_ramp_stage.sv
// Multi-channel gain stage with linear gain ramping and valid/ready flow.
// GAIN_ROUND_EN (in gain_mac_sat) selects rounding instead of truncation.
module gain_ramp_stage
    import gains_pkg::*;
#(
    parameter int DATA_W      = 24,
    parameter int CHANNELS    = 2,
    parameter int GAIN_INT_W  = 4,
    parameter int GAIN_FRAC_W = 2,
    parameter int RAMP_STEP   = 1,
    parameter int RESET_GAIN  = 1 << GAIN_FRAC_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [GAIN_INT_W+GAIN_FRAC_W-1:0] gain_target,
    input  logic                             gain_load,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [CHANNELS*DATA_W-1:0]       s_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [CHANNELS*DATA_W-1:0]       m_data,
    output logic [GAIN_INT_W+GAIN_FRAC_W-1:0] gain_current,
    output logic                             ramp_busy,
    output logic                             sat_pulse
);

    localparam int GW = gain_w(GAIN_INT_W, GAIN_FRAC_W);
    localparam logic [GW-1:0] STEP  = GW'(RAMP_STEP);
    localparam logic [GW-1:0] RST_G = GW'(RESET_GAIN);

    logic                adv;
    logic                accept;
    logic                v1;
    logic                v2;
    logic [CHANNELS-1:0] clip;
    ramp_state_t         state;
    ramp_state_t         state_n;
    logic [GW-1:0]       cur;
    logic [GW-1:0]       cur_n;
    logic [GW-1:0]       tgt;
    logic [GW-1:0]       tgt_n;

    assign adv          = !(v2 && !m_ready);
    assign s_ready      = adv;
    assign accept       = s_valid && adv;
    assign m_valid      = v2;
    assign gain_current = cur;
    assign ramp_busy    = (state == RAMPING);

    // Per-channel datapath; all channels share the current gain.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        gain_mac_sat #(
            .DATA_W      (DATA_W),
            .GAIN_W      (GW),
            .GAIN_FRAC_W (GAIN_FRAC_W)
        ) u_mac (
            .clk   (clk),
            .rst_n (rst_n),
            .en1   (accept),
            .en2   (adv && v1),
            .data  (s_data[c*DATA_W +: DATA_W]),
            .gain  (cur),
            .out   (m_data[c*DATA_W +: DATA_W]),
            .clip  (clip[c])
        );
    end

    // Pipeline valids and the clip pulse of the frame entering stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            sat_pulse <= 1'b0;
        end else if (adv) begin
            v1        <= s_valid;
            v2        <= v1;
            sat_pulse <= v1 && (|clip);
        end else begin
            sat_pulse <= 1'b0;
        end
    end

    // Ramp FSM state, gain and target registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETTLED;
            cur   <= RST_G;
            tgt   <= RST_G;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            tgt   <= tgt_n;
        end
    end

    // Step the gain toward the target once per accepted frame.
    always_comb begin
        tgt_n   = gain_load ? gain_target : tgt;
        cur_n   = cur;
        state_n = state;
        if (accept && (state == RAMPING || gain_load)) begin
            if (tgt_n > cur)
                cur_n = ((tgt_n - cur) > STEP) ? cur + STEP : tgt_n;
            else if (tgt_n < cur)
                cur_n = ((cur - tgt_n) > STEP) ? cur - STEP : tgt_n;
        end
        state_n = (cur_n != tgt_n) ? RAMPING : SETTLED;
    end

endmodule

// File: tb/tb_gain_ramp_stage.sv
// Directed bench for gain_ramp_stage (default parameters).
// Expected values are hand-computed per step.
module tb_gain_ramp_stage;

    logic        clk;
    logic        rst_n;
    logic [5:0]  gain_target;
    logic        gain_load;
    logic        s_valid;
    logic        s_ready;
    logic [47:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [47:0] m_data;
    logic [5:0]  gain_current;
    logic        ramp_busy;
    logic        sat_pulse;

    int n_cmp;
    int n_bad;

    gain_ramp_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gain_target  (gain_target),
        .gain_load    (gain_load),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .gain_current (gain_current),
        .ramp_busy    (ramp_busy),
        .sat_pulse    (sat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_one(input string tag, input logic [23:0] d0,
                            input logic [23:0] d1, input logic [23:0] e0,
                            input logic [23:0] e1, input logic es);
        s_valid = 1'b1;
        s_data  = {d1, d0};
        tick();
        s_valid = 1'b0;
        tick();
        chk({tag, "_valid"}, 64'(m_valid), 64'd1);
        chk({tag, "_data"}, 64'(m_data), 64'({e1, e0}));
        chk({tag, "_sat"}, 64'(sat_pulse), 64'(es));
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        gain_target = '0;
        gain_load   = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        m_ready     = 1'b1;
        tick();
        tick();
        chk("rst_mvalid", 64'(m_valid), 64'd0);
        chk("rst_mdata", 64'(m_data), 64'd0);
        chk("rst_gain", 64'(gain_current), 64'd4);
        chk("rst_busy", 64'(ramp_busy), 64'd0);
        chk("rst_sat", 64'(sat_pulse), 64'd0);
        chk("rst_sready", 64'(s_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // unity passthrough, 2-cycle latency
        send_one("unity", 24'h000100, 24'h000100,
                 24'h000100, 24'h000100, 1'b0);
        tick();
        chk("unity_drain", 64'(m_valid), 64'd0);

        // ramp 1.0 -> 1.5 over accepted frames
        gain_target = 6'h06;
        gain_load   = 1'b1;
        tick();
        gain_load = 1'b0;
        chk("ld_busy", 64'(ramp_busy), 64'd1);
        chk("ld_gain", 64'(gain_current), 64'd4);
        s_valid = 1'b1;
        s_data  = {24'h000100, 24'h000100};
        tick();
        chk("r1_gain", 64'(gain_current), 64'd5);
        chk("r1_busy", 64'(ramp_busy), 64'd1);
        tick();
        chk("r2_gain", 64'(gain_current), 64'd6);
        chk("r2_busy", 64'(ramp_busy), 64'd0);
        chk("r2_data", 64'(m_data), 64'h000100_000100);
        tick();
        chk("r3_data", 64'(m_data), 64'h000140_000140);
        tick();
        s_valid = 1'b0;
        chk("r4_data", 64'(m_data), 64'h000180_000180);
        tick();
        chk("r5_data", 64'(m_data), 64'h000180_000180);
        chk("r5_valid", 64'(m_valid), 64'd1);
        tick();

        // ramp up to 15.0 and saturate
        gain_target = 6'h3C;
        gain_load   = 1'b1;
        tick();
        gain_load = 1'b0;
        s_valid   = 1'b1;
        s_data    = '0;
        for (int i = 0; i < 60; i++) tick();
        s_valid = 1'b0;
        tick();
        tick();
        chk("hi_gain", 64'(gain_current), 64'h3C);
        chk("hi_busy", 64'(ramp_busy), 64'd0);
        send_one("satp", 24'h7FFFFF, 24'h7FFFFF,
                 24'h7FFFFF, 24'h7FFFFF, 1'b1);
        tick();
        chk("satp_pulse_end", 64'(sat_pulse), 64'd0);
        send_one("satn", 24'h800000, 24'h800000,
                 24'h800000, 24'h800000, 1'b1);
        send_one("satmix", 24'h000001, 24'h7FFFFF,
                 24'h00000F, 24'h7FFFFF, 1'b1);
        send_one("nosat", 24'h000004, 24'hFFFFFC,
                 24'h00003C, 24'hFFFFC4, 1'b0);
        tick();

        // ramp down to 0.25 and check shift behaviour
        gain_target = 6'h01;
        gain_load   = 1'b1;
        tick();
        gain_load = 1'b0;
        s_valid   = 1'b1;
        s_data    = '0;
        for (int i = 0; i < 64; i++) tick();
        s_valid = 1'b0;
        tick();
        tick();
        chk("lo_gain", 64'(gain_current), 64'd1);
        gain_target = 6'h01;
        gain_load   = 1'b1;
        tick();
        gain_load = 1'b0;
        chk("same_busy", 64'(ramp_busy), 64'd0);
`ifdef GAIN_ROUND_EN
        send_one("quarter", 24'hFFFFFD, 24'h000002,
                 24'hFFFFFF, 24'h000001, 1'b0);
`else
        send_one("quarter", 24'hFFFFFD, 24'h000002,
                 24'hFFFFFF, 24'h000000, 1'b0);
`endif
        tick();

        // stall with a ramp in progress
        gain_target = 6'h08;
        gain_load   = 1'b1;
        tick();
        gain_load = 1'b0;
        m_ready   = 1'b0;
        s_valid   = 1'b1;
        s_data    = {24'd4, 24'd4};
        tick();
        s_data = {24'd8, 24'd8};
        tick();
        chk("stl_valid", 64'(m_valid), 64'd1);
        chk("stl_data", 64'(m_data), 64'h000001_000001);
        chk("stl_sready", 64'(s_ready), 64'd0);
        chk("stl_gain", 64'(gain_current), 64'd3);
        s_data = {24'd12, 24'd12};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_data", 64'(m_data), 64'h000001_000001);
            chk("hold_valid", 64'(m_valid), 64'd1);
            chk("hold_sready", 64'(s_ready), 64'd0);
            chk("hold_gain", 64'(gain_current), 64'd3);
        end
        m_ready = 1'b1;
        #1;
        chk("rel_sready", 64'(s_ready), 64'd1);
        tick();
        s_valid = 1'b0;
        chk("rel1_data", 64'(m_data), 64'h000004_000004);
        chk("rel1_gain", 64'(gain_current), 64'd4);
        tick();
        chk("rel2_data", 64'(m_data), 64'h000009_000009);
        chk("rel2_valid", 64'(m_valid), 64'd1);
        tick();
        chk("rel3_valid", 64'(m_valid), 64'd0);

        // reset mid-ramp with two frames in flight
        s_valid = 1'b1;
        s_data  = {24'h000100, 24'h000100};
        tick();
        tick();
        chk("pre_rst_valid", 64'(m_valid), 64'd1);
        chk("pre_rst_gain", 64'(gain_current), 64'd6);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(m_valid), 64'd0);
        chk("mrst_data", 64'(m_data), 64'd0);
        chk("mrst_gain", 64'(gain_current), 64'd4);
        chk("mrst_busy", 64'(ramp_busy), 64'd0);
        s_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_one("post_rst", 24'h000100, 24'h000200,
                 24'h000100, 24'h000200, 1'b0);
        tick();
        chk("post_rst_valid", 64'(m_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
